// File: rtl/bloom_req_seq_if.sv
// rtl/bloom_req_seq_if.sv - request, response and Bloom filter strobe bundle for bloom_req_seq
//
// Purpose : groups the request queue handshake, the response handshake and
//           the downstream filter strobes/result into one bundle.
// Signals : req_valid/req_ready/req_op/req_data  request channel
//           rsp_valid/rsp_ready/rsp_op/rsp_match/rsp_err  response channel
//           bf_data/bf_insert/bf_check/bf_reset/bf_match  filter stage
//           ins_count  inserts since last clear/reset
// Modports: slave  = sequencer side, master = requester/filter side

interface bloom_req_seq_if #(
    parameter int D_SIZE = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [D_SIZE:0]   req_data;

    logic [D_SIZE:0]   bf_data;
    logic              bf_insert;
    logic              bf_check;
    logic              bf_reset;
    logic              bf_match;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_op;
    logic              rsp_match;
    logic              rsp_err;

    logic [15:0]       ins_count;

    modport slave (
        input  req_valid, req_op, req_data, bf_match, rsp_ready,
        output req_ready, bf_data, bf_insert, bf_check, bf_reset,
               rsp_valid, rsp_op, rsp_match, rsp_err, ins_count
    );

    modport master (
        output req_valid, req_op, req_data, bf_match, rsp_ready,
        input  req_ready, bf_data, bf_insert, bf_check, bf_reset,
               rsp_valid, rsp_op, rsp_match, rsp_err, ins_count
    );
endinterface

// File: rtl/bloom_req_seq.sv
// rtl/bloom_req_seq.sv - in-order request sequencer driving a Bloom filter stage
//
// Purpose : queues insert/check/clear requests in a DEPTH-entry FIFO and
//           executes them one at a time against a downstream Bloom filter,
//           returning one response per request in FIFO order.
// Ports   : clk    single clock, rising edge
//           reset  synchronous active-low reset
//           bus    bloom_req_seq_if.slave (request, response, filter signals)
// Params  : D_SIZE (key width D_SIZE+1), DEPTH (power of two, >=2),
//           MATCH_LAT (cycles from bf_check to bf_match sample, >=1)

module bloom_req_seq #(
    parameter int D_SIZE    = 8,
    parameter int DEPTH     = 4,
    parameter int MATCH_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    bloom_req_seq_if.slave     bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = (MATCH_LAT > 2) ? $clog2(MATCH_LAT) : 1;
    // Index of the last WAIT cycle; unused when MATCH_LAT == 1
    localparam logic [WCW-1:0] W_LAST = (MATCH_LAT > 1) ? WCW'(MATCH_LAT - 2) : '0;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_CHK = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_op_mem   [DEPTH];
    logic [D_SIZE:0] r_data_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic [1:0]      r_op;
    logic [D_SIZE:0] r_data;
    logic            r_match;
    logic [WCW-1:0]  r_wcnt;
    logic [15:0]     r_ins_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_ins;
    logic            w_chk;
    logic            w_rst;
    logic            w_sample;
    logic [D_SIZE:0] w_bf_data;
    logic            w_rsp_valid;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.req_valid && !w_full;
    // Only IDLE pulls from the FIFO, which keeps exactly one request in flight
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    // Request FIFO; ready is derived from the registered count so a pop
    // only frees a slot from the following cycle on
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_op_mem[r_wptr]   <= bus.req_op;
                r_data_mem[r_wptr] <= bus.req_data;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ins     = 1'b0;
        w_chk     = 1'b0;
        w_rst     = 1'b0;
        w_sample  = 1'b0;
        w_bf_data = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (r_op)
                    OP_INS: begin
                        w_ins     = 1'b1;
                        w_bf_data = r_data;
                    end
                    OP_CHK: begin
                        w_chk     = 1'b1;
                        w_bf_data = r_data;
                    end
                    OP_CLR:  w_rst = 1'b1;
                    default: ;
                endcase
                if (r_op == OP_CHK && MATCH_LAT > 1) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_RESP;
                    // With a one-cycle filter the result is taken at the ISSUE edge
                    if (r_op == OP_CHK) begin
                        w_sample = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_bf_data = r_data;
                if (r_wcnt == W_LAST) begin
                    w_sample = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Holding register, match capture, wait counter and insert counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op        <= '0;
            r_data      <= '0;
            r_match     <= 1'b0;
            r_wcnt      <= '0;
            r_ins_count <= '0;
        end else begin
            if (w_pop) begin
                r_op   <= r_op_mem[r_rptr];
                r_data <= r_data_mem[r_rptr];
            end
            if (w_sample) begin
                r_match <= bus.bf_match;
            end else if (r_state == S_ISSUE) begin
                r_match <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_wcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_rst) begin
                r_ins_count <= '0;
            end else if (w_ins && r_ins_count != 16'hFFFF) begin
                r_ins_count <= r_ins_count + 16'd1;
            end
        end
    end

    assign w_rsp_valid   = (r_state == S_RESP);

    assign bus.req_ready = !w_full;
    assign bus.bf_data   = w_bf_data;
    assign bus.bf_insert = w_ins;
    assign bus.bf_check  = w_chk;
    assign bus.bf_reset  = w_rst;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_op    = w_rsp_valid ? r_op : 2'b00;
    assign bus.rsp_match = w_rsp_valid && r_match;
    assign bus.rsp_err   = w_rsp_valid && (r_op == OP_RSV);
    assign bus.ins_count = r_ins_count;
endmodule

// File: tb/tb_bloom_req_seq.sv
// tb/tb_bloom_req_seq.sv - scoreboard testbench for bloom_req_seq

module tb_bloom_req_seq;
    localparam int D_SIZE = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bloom_req_seq_if #(.D_SIZE(D_SIZE)) bus ();

    bloom_req_seq #(
        .D_SIZE    (D_SIZE),
        .DEPTH     (4),
        .MATCH_LAT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  exp_q [$];
    bit          e_set [512];
    bit          f_set [512];
    logic [15:0] exp_ins = 16'd0;
    int          n_ins = 0;
    int          n_chk = 0;
    int          n_rst = 0;
    logic        prev_hold = 1'b0;
    logic [1:0]  prev_op = 2'b00;
    logic [3:0]  e_rsp;
    int          base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Filter model plus response scoreboard, sampled away from the rising edge
    always @(negedge clk) begin
        if (reset) begin
            if (bus.bf_insert || bus.bf_check || bus.bf_reset) begin
                chk("strobe_onehot", $countones({bus.bf_insert, bus.bf_check, bus.bf_reset}), 1);
                if (bus.bf_insert) begin
                    f_set[bus.bf_data] = 1'b1;
                    n_ins++;
                end
                if (bus.bf_check) n_chk++;
                if (bus.bf_reset) begin
                    foreach (f_set[i]) f_set[i] = 1'b0;
                    n_rst++;
                end
            end
            if (prev_hold) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1);
                chk("rsp_hold_op", bus.rsp_op, prev_op);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_rsp = exp_q.pop_front();
                    chk("rsp_op", bus.rsp_op, e_rsp[3:2]);
                    chk("rsp_match", bus.rsp_match, e_rsp[1]);
                    chk("rsp_err", bus.rsp_err, e_rsp[0]);
                end
            end
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_op   = bus.rsp_op;
        end else begin
            prev_hold = 1'b0;
        end
        bus.bf_match = f_set[bus.bf_data];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [8:0] key);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = key;
        while (!bus.req_ready && t < 300) begin
            tick();
            t++;
        end
        chk("req_accept_in_time", t < 300, 1);
        case (op)
            2'b00: begin
                e_set[key] = 1'b1;
                if (exp_ins != 16'hFFFF) exp_ins = exp_ins + 16'd1;
                exp_q.push_back({op, 1'b0, 1'b0});
            end
            2'b01: exp_q.push_back({op, e_set[key], 1'b0});
            2'b10: begin
                foreach (e_set[i]) e_set[i] = 1'b0;
                exp_ins = 16'd0;
                exp_q.push_back({op, 1'b0, 1'b0});
            end
            default: exp_q.push_back({op, 1'b0, 1'b1});
        endcase
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            tick();
            t++;
        end
        chk("drain_in_time", t < 1000, 1);
        repeat (2) tick();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_op"}, bus.rsp_op, 0);
        chk({tag, "_rsp_match"}, bus.rsp_match, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_strobes"}, {bus.bf_insert, bus.bf_check, bus.bf_reset}, 0);
        chk({tag, "_bf_data"}, bus.bf_data, 0);
        chk({tag, "_ins_count"}, bus.ins_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        reset = 1'b0;
        repeat (3) tick();
        check_quiet("in_reset");
        reset = 1'b1;
        tick();
        check_quiet("post_reset");

        // Insert then check the same key; then check an absent key
        base = n_ins;
        send(2'b00, 9'h005);
        send(2'b01, 9'h005);
        drain();
        chk("ins_pulses", n_ins - base, 1);
        chk("ins_count_1", bus.ins_count, exp_ins);
        send(2'b01, 9'h01A);
        drain();

        // Clear after three inserts
        send(2'b10, 9'h000);
        send(2'b00, 9'h001);
        send(2'b00, 9'h002);
        send(2'b00, 9'h003);
        drain();
        chk("ins_count_3", bus.ins_count, 16'd3);
        base = n_rst;
        send(2'b10, 9'h000);
        drain();
        chk("clear_pulses", n_rst - base, 1);
        chk("ins_count_cleared", bus.ins_count, 16'd0);
        send(2'b01, 9'h002);
        drain();

        // Reserved opcode: error response, no strobe
        base = n_ins + n_chk + n_rst;
        send(2'b11, 9'h055);
        drain();
        chk("rsv_no_strobe", n_ins + n_chk + n_rst - base, 0);

        // Five back-to-back requests under response back-pressure
        bus.rsp_ready = 1'b0;
        send(2'b00, 9'h010);
        send(2'b01, 9'h010);
        send(2'b00, 9'h011);
        send(2'b01, 9'h012);
        send(2'b01, 9'h011);
        chk("full_req_ready", bus.req_ready, 0);
        repeat (5) tick();
        chk("full_still_not_ready", bus.req_ready, 0);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_queue_held", exp_q.size(), 5);
        bus.rsp_ready = 1'b1;
        drain();
        chk("bp_ins_count", bus.ins_count, exp_ins);

        // Insert counter saturation
        force dut.r_ins_count = 16'hFFFE;
        tick();
        release dut.r_ins_count;
        exp_ins = 16'hFFFE;
        send(2'b00, 9'h007);
        drain();
        chk("sat_reach", bus.ins_count, 16'hFFFF);
        send(2'b00, 9'h008);
        drain();
        chk("sat_hold", bus.ins_count, 16'hFFFF);

        // Reset while a check waits with two more queued
        send(2'b01, 9'h005);
        send(2'b01, 9'h006);
        send(2'b01, 9'h007);
        chk("in_wait_bf_data", bus.bf_data, 9'h005);
        reset = 1'b0;
        exp_q.delete();
        exp_ins = 16'd0;
        tick();
        check_quiet("mid_reset");
        reset = 1'b1;
        base = n_ins + n_chk + n_rst;
        repeat (20) tick();
        chk("no_stale_strobes", n_ins + n_chk + n_rst - base, 0);
        chk("no_stale_rsp", bus.rsp_valid, 0);
        chk("post_mid_ins", bus.ins_count, exp_ins);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
